mips_cpu_bus_arbiter: RTL and testbench
=======================================

Name: mips_cpu_bus_arbiter

Overview:
- Shares the CPU's single Avalon memory-mapped master port between two requesters: instruction fetch and data load/store.
- Latches one request at a time and holds bus signals stable across waitrequest.
- Returns a one-cycle ack with captured readdata to the winning requester.
- Sits between the CPU control FSM and the top-level Avalon port of mips_cpu_bus.

Parameters:
- DATA_FIRST, 1, 1 = data requester wins simultaneous requests; 0 = round-robin (alternate from last grant).
- TIMEOUT_CYCLES, 256, waitrequest cycles tolerated before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request; held high until inst_ack
- inst_addr  in  32  fetch word address
- inst_ack  out  1  one-cycle pulse: fetch complete
- inst_rdata  out  32  fetched word; valid while inst_ack=1
- data_req  in  1  load/store request; held high until data_ack
- data_we  in  1  1 = store, 0 = load
- data_addr  in  32  data address
- data_wdata  in  32  store data
- data_be  in  4  byte enables
- data_ack  out  1  one-cycle pulse: data access complete
- data_rdata  out  32  load word; valid while data_ack=1
- bus_err  out  1  pulses with ack on aborted transfer (tied 0 without feature)
- address  out  32  Avalon address
- read  out  1  Avalon read
- write  out  1  Avalon write
- writedata  out  32  Avalon writedata
- byteenable  out  4  Avalon byteenable
- waitrequest  in  1  Avalon waitrequest
- readdata  in  32  Avalon readdata (zero read latency)

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high. While reset is high, all outputs are 0, state = IDLE, and the round-robin pointer = inst.
- States: IDLE, BUSY_INST, BUSY_DATA, DONE.
- IDLE:
  - No request: stay in IDLE, bus idle (read=write=0).
  - One request: latch its address, writedata, byteenable and direction; go to BUSY of the winner.
  - Fetch is always a read with byteenable=4'b1111.
  - Data byteenable = data_be for both loads and stores.
  - Both requests: DATA_FIRST=1 grants data; DATA_FIRST=0 grants the requester not granted last.
- BUSY_*:
  - address, read/write, writedata and byteenable are driven from registers, constant for the whole state.
  - Completion occurs at the edge where waitrequest=0. At that edge, capture readdata (loads and fetches) into the winner's rdata register, then go to DONE.
  - waitrequest=1: hold every bus output unchanged.
- DONE:
  - Exactly one cycle; the winner's ack is high and the bus is idle.
  - Requests are ignored in DONE, so a requester still holding req during its ack cycle is not reissued.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle 0, bus asserted in cycle 1, ack in cycle 2 if there is no wait. Each waitrequest cycle adds one cycle.
- Stores: data_rdata is unchanged; ack still pulses.
- Never asserts read and write together; never asserts either outside BUSY.
- Request inputs change while BUSY: ignored, because values were latched at grant.
- A requester dropping req mid-transfer does not abort the transfer; the ack still pulses.
- Reset mid-transfer: read/write drop combinationally with reset; any pending ack is lost.
- rdata registers hold their last value between acks.

Optional Feature:
- MIPS_BUS_TIMEOUT_EN defined:
  - A counter clears on entry to BUSY and increments each cycle waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES: drop read/write, go to DONE, pulse the winner's ack with bus_err=1 and rdata set to 32'h0.
  - In simulation, issue $error.
- Undefined: no counter; waits indefinitely; bus_err is constant 0.

Decomposition:
- Shared package (mips_cpu_definitions): arb_state_t enum (IDLE, BUSY_INST, BUSY_DATA, DONE) and constant BE_WORD = 4'b1111.
- Natural sub-module: mips_cpu_bus_timeout (counter + compare, instantiated only under MIPS_BUS_TIMEOUT_EN).

Test Plan:
- inst_req with addr 32'hBFC00000, waitrequest=0, readdata=32'h24020005 -> read=1 with address BFC00000 in cycle 1; inst_ack with inst_rdata=24020005 in cycle 2.
- Store: data_we=1, addr 32'h00001004, wdata 32'hDEADBEEF, be 4'b0011, waitrequest high 3 cycles -> write/address/writedata/byteenable stable for 4 cycles; single data_ack; read never high.
- Simultaneous inst_req+data_req with DATA_FIRST=1 -> data served first, then inst. With DATA_FIRST=0 and repeated double requests -> grants alternate inst, data, inst.
- Requester holds req through the ack cycle -> exactly one bus transaction and one ack.
- Assert reset while BUSY with waitrequest=1 -> read=0 immediately; no ack follows; the next request proceeds normally.
- With MIPS_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=8, waitrequest stuck at 1 -> ack and bus_err pulse 9 cycles after bus assert; rdata=0; state returns to IDLE.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter_pkg.sv
// mips_cpu_definitions: shared types and constants for the CPU bus arbiter.
//   arb_state_t : arbiter FSM states (IDLE, BUSY_INST, BUSY_DATA, DONE)
//   BE_WORD     : byteenable pattern for a full-word access (instruction fetch)
package mips_cpu_definitions;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_INST = 2'd1,
    BUSY_DATA = 2'd2,
    DONE      = 2'd3
  } arb_state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/mips_cpu_bus_timeout.sv
// mips_cpu_bus_timeout: waitrequest watchdog for the bus arbiter.
// Only compiled when MIPS_BUS_TIMEOUT_EN is defined.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count (arbiter entering a BUSY state)
//   count_en   : one stalled cycle (BUSY with waitrequest=1)
//   expired    : count has reached TIMEOUT_CYCLES
`ifdef MIPS_BUS_TIMEOUT_EN
module mips_cpu_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int            CW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_r;

  // Stall counter; saturates at the limit so expired stays asserted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (count_en && (count_r != LIMIT)) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LIMIT);

`ifndef SYNTHESIS
  // Report the abort in simulation at the edge where it takes effect.
  always_ff @(posedge clk) begin
    if (!reset && count_en && expired) begin
      $error("mips_cpu_bus_timeout: waitrequest held for %0d cycles, transfer aborted", TIMEOUT_CYCLES);
    end else begin
    end
  end
`endif

endmodule
`endif

// File: rtl/mips_cpu_bus_arbiter.sv
// mips_cpu_bus_arbiter: shares one Avalon-MM master port between the
// instruction-fetch and data load/store requesters.
// One request is latched at a time; bus outputs come from registers and are
// held across waitrequest. The winner gets a one-cycle ack with readdata.
// Optional feature macro: MIPS_BUS_TIMEOUT_EN (waitrequest watchdog, bus_err).
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   inst_req/inst_addr               : fetch request (held until inst_ack)
//   inst_ack/inst_rdata              : fetch completion pulse and fetched word
//   data_req/we/addr/wdata/be        : load/store request (held until data_ack)
//   data_ack/data_rdata              : data completion pulse and load word
//   bus_err                          : pulses with ack on an aborted transfer
//   address/read/write/writedata/byteenable/waitrequest/readdata : Avalon master
module mips_cpu_bus_arbiter
  import mips_cpu_definitions::*;
#(
  parameter int DATA_FIRST     = 1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_ack,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_be,
  output logic        data_ack,
  output logic [31:0] data_rdata,
  output logic        bus_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  arb_state_t  state_r, state_nxt_s;
  logic        rr_data_r, rr_data_nxt_s;   // 1: data wins the next tie (round-robin)
  logic        grant_data_s;
  logic        abort_s;
  logic        read_nxt_s, write_nxt_s;
  logic        inst_ack_nxt_s, data_ack_nxt_s, bus_err_nxt_s;
  logic [31:0] address_nxt_s, writedata_nxt_s;
  logic [31:0] inst_rdata_nxt_s, data_rdata_nxt_s;
  logic [3:0]  byteenable_nxt_s;

  // Data wins when it is alone, or on a tie under fixed priority / its round-robin turn.
  assign grant_data_s = data_req && (!inst_req || (DATA_FIRST != 0) || rr_data_r);

`ifdef MIPS_BUS_TIMEOUT_EN
  logic busy_s, tmo_clear_s;

  assign busy_s      = (state_r == BUSY_INST) || (state_r == BUSY_DATA);
  assign tmo_clear_s = (state_r == IDLE) && (inst_req || data_req);

  mips_cpu_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear_s),
    .count_en(busy_s && waitrequest),
    .expired (abort_s)
  );
`else
  assign abort_s = 1'b0;
`endif

  // Next-state and next-output logic; bus fields change only on grant.
  always_comb begin
    state_nxt_s      = state_r;
    rr_data_nxt_s    = rr_data_r;
    address_nxt_s    = address;
    writedata_nxt_s  = writedata;
    byteenable_nxt_s = byteenable;
    read_nxt_s       = read;
    write_nxt_s      = write;
    inst_ack_nxt_s   = 1'b0;
    data_ack_nxt_s   = 1'b0;
    bus_err_nxt_s    = 1'b0;
    inst_rdata_nxt_s = inst_rdata;
    data_rdata_nxt_s = data_rdata;

    case (state_r)
      IDLE: begin
        if (inst_req || data_req) begin
          if (grant_data_s) begin
            state_nxt_s      = BUSY_DATA;
            rr_data_nxt_s    = 1'b0;
            address_nxt_s    = data_addr;
            writedata_nxt_s  = data_wdata;
            byteenable_nxt_s = data_be;
            read_nxt_s       = !data_we;
            write_nxt_s      = data_we;
          end else begin
            state_nxt_s      = BUSY_INST;
            rr_data_nxt_s    = 1'b1;
            address_nxt_s    = inst_addr;
            writedata_nxt_s  = 32'h0000_0000;
            byteenable_nxt_s = BE_WORD;
            read_nxt_s       = 1'b1;
            write_nxt_s      = 1'b0;
          end
        end else begin
          read_nxt_s  = 1'b0;
          write_nxt_s = 1'b0;
        end
      end
      BUSY_INST, BUSY_DATA: begin
        if (!waitrequest) begin
          state_nxt_s = DONE;
          read_nxt_s  = 1'b0;
          write_nxt_s = 1'b0;
          if (state_r == BUSY_INST) begin
            inst_ack_nxt_s   = 1'b1;
            inst_rdata_nxt_s = readdata;
          end else begin
            data_ack_nxt_s = 1'b1;
            // A store leaves the load register untouched.
            if (!write) begin
              data_rdata_nxt_s = readdata;
            end else begin
              data_rdata_nxt_s = data_rdata;
            end
          end
        end else if (abort_s) begin
          state_nxt_s   = DONE;
          read_nxt_s    = 1'b0;
          write_nxt_s   = 1'b0;
          bus_err_nxt_s = 1'b1;
          if (state_r == BUSY_INST) begin
            inst_ack_nxt_s   = 1'b1;
            inst_rdata_nxt_s = 32'h0000_0000;
          end else begin
            data_ack_nxt_s   = 1'b1;
            data_rdata_nxt_s = 32'h0000_0000;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      DONE: begin
        // Requests are deliberately not sampled here so a held req is not reissued.
        state_nxt_s = IDLE;
        read_nxt_s  = 1'b0;
        write_nxt_s = 1'b0;
      end
      default: begin
        state_nxt_s = IDLE;
        read_nxt_s  = 1'b0;
        write_nxt_s = 1'b0;
      end
    endcase
  end

  // State and round-robin pointer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      rr_data_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      rr_data_r <= rr_data_nxt_s;
    end
  end

  // Registered bus and requester-facing outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      address    <= 32'h0000_0000;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= 32'h0000_0000;
      byteenable <= 4'b0000;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      bus_err    <= 1'b0;
      inst_rdata <= 32'h0000_0000;
      data_rdata <= 32'h0000_0000;
    end else begin
      address    <= address_nxt_s;
      read       <= read_nxt_s;
      write      <= write_nxt_s;
      writedata  <= writedata_nxt_s;
      byteenable <= byteenable_nxt_s;
      inst_ack   <= inst_ack_nxt_s;
      data_ack   <= data_ack_nxt_s;
      bus_err    <= bus_err_nxt_s;
      inst_rdata <= inst_rdata_nxt_s;
      data_rdata <= data_rdata_nxt_s;
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Bench for mips_cpu_bus_arbiter: instance 0 uses DATA_FIRST=1, instance 1
// uses DATA_FIRST=0. Both share the Avalon slave stimulus; each has its own
// request lines. A transaction-level model predicts every output each cycle.
module tb_mips_cpu_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  inst_req, data_req;
  logic [31:0] inst_addr, data_addr, data_wdata, readdata;
  logic        data_we, waitrequest;
  logic [3:0]  data_be;
  logic [1:0]  inst_ack, data_ack, bus_err, rd, wr;
  logic [31:0] inst_rdata [2];
  logic [31:0] data_rdata [2];
  logic [31:0] address [2];
  logic [31:0] writedata [2];
  logic [3:0]  byteenable [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit auto_drop = 1'b1;

  mips_cpu_bus_arbiter #(.DATA_FIRST(1)) u_dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req[0]), .inst_addr(inst_addr), .inst_ack(inst_ack[0]), .inst_rdata(inst_rdata[0]),
    .data_req(data_req[0]), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_ack(data_ack[0]), .data_rdata(data_rdata[0]), .bus_err(bus_err[0]),
    .address(address[0]), .read(rd[0]), .write(wr[0]), .writedata(writedata[0]),
    .byteenable(byteenable[0]), .waitrequest(waitrequest), .readdata(readdata)
  );

  mips_cpu_bus_arbiter #(.DATA_FIRST(0)) u_rr (
    .clk(clk), .reset(reset),
    .inst_req(inst_req[1]), .inst_addr(inst_addr), .inst_ack(inst_ack[1]), .inst_rdata(inst_rdata[1]),
    .data_req(data_req[1]), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_be(data_be), .data_ack(data_ack[1]), .data_rdata(data_rdata[1]), .bus_err(bus_err[1]),
    .address(address[1]), .read(rd[1]), .write(wr[1]), .writedata(writedata[1]),
    .byteenable(byteenable[1]), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // Each arbiter is either idle, carrying one transaction on the bus, or
  // reporting the completion of the previous one for a single cycle.
  typedef struct {
    bit          on_bus;
    bit          for_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
  } txn_t;

  txn_t        m_txn [2];
  bit          m_ack_i [2];
  bit          m_ack_d [2];
  bit          m_turn_data [2];
  logic [31:0] m_rd_i [2];
  logic [31:0] m_rd_d [2];

  always @(posedge clk or posedge reset) begin : model
    bit take_data;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_txn[k]       = '{default: '0};
        m_ack_i[k]     = 1'b0;
        m_ack_d[k]     = 1'b0;
        m_turn_data[k] = 1'b0;
        m_rd_i[k]      = 32'h0;
        m_rd_d[k]      = 32'h0;
      end else if (m_ack_i[k] || m_ack_d[k]) begin
        m_ack_i[k] = 1'b0;
        m_ack_d[k] = 1'b0;
      end else if (m_txn[k].on_bus) begin
        if (!waitrequest) begin
          m_txn[k].on_bus = 1'b0;
          if (m_txn[k].for_data) begin
            m_ack_d[k] = 1'b1;
            if (!m_txn[k].we) m_rd_d[k] = readdata;
          end else begin
            m_ack_i[k] = 1'b1;
            m_rd_i[k]  = readdata;
          end
        end
      end else if (inst_req[k] || data_req[k]) begin
        take_data = data_req[k] && (!inst_req[k] || k == 0 || m_turn_data[k]);
        m_turn_data[k] = !take_data;
        if (take_data)
          m_txn[k] = '{on_bus: 1'b1, for_data: 1'b1, we: data_we, addr: data_addr, wd: data_wdata, be: data_be};
        else
          m_txn[k] = '{on_bus: 1'b1, for_data: 1'b0, we: 1'b0, addr: inst_addr, wd: 32'h0, be: 4'b1111};
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("read[%0d]", k), rd[k], m_txn[k].on_bus && !m_txn[k].we);
      chk($sformatf("write[%0d]", k), wr[k], m_txn[k].on_bus && m_txn[k].we);
      chk($sformatf("inst_ack[%0d]", k), inst_ack[k], m_ack_i[k]);
      chk($sformatf("data_ack[%0d]", k), data_ack[k], m_ack_d[k]);
      chk($sformatf("inst_rdata[%0d]", k), inst_rdata[k], m_rd_i[k]);
      chk($sformatf("data_rdata[%0d]", k), data_rdata[k], m_rd_d[k]);
      chk($sformatf("bus_err[%0d]", k), bus_err[k], 32'h0);
      if (m_txn[k].on_bus) begin
        chk($sformatf("address[%0d]", k), address[k], m_txn[k].addr);
        chk($sformatf("byteenable[%0d]", k), byteenable[k], m_txn[k].be);
        if (m_txn[k].we) chk($sformatf("writedata[%0d]", k), writedata[k], m_txn[k].wd);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (auto_drop) begin
      for (int k = 0; k < 2; k++) begin
        if (inst_ack[k]) inst_req[k] = 1'b0;
        if (data_ack[k]) data_req[k] = 1'b0;
      end
    end
  endtask

  // Wait (bounded) until each instance has shown one ack; report which kind.
  task automatic wait_acks(input string name, output logic [1:0] was_data);
    logic [1:0] got;
    got = 2'b00;
    was_data = 2'b00;
    for (int c = 0; c < 20 && got != 2'b11; c++) begin
      tick();
      for (int k = 0; k < 2; k++) begin
        if (!got[k] && (inst_ack[k] || data_ack[k])) begin
          got[k] = 1'b1;
          was_data[k] = data_ack[k];
        end
      end
    end
    chk(name, {30'h0, got}, 32'h3);
  endtask

  initial begin
    logic [3:0] gr0, gr1;
    logic [1:0] wd;
    int wcnt, acks, reads;
    bit rseen;

    inst_req = 2'b00; data_req = 2'b00; inst_addr = 32'h0; data_addr = 32'h0;
    data_wdata = 32'h0; data_we = 1'b0; data_be = 4'b0000; waitrequest = 1'b0; readdata = 32'h0;
    #1 reset = 1'b1;
    tick(); tick();
    chk("rst_read", {31'h0, rd[0]}, 32'h0);
    chk("rst_address", address[0], 32'h0);
    reset = 1'b0;
    tick();

    // Fetch with no wait: bus in cycle 1, ack in cycle 2.
    inst_addr = 32'hBFC0_0000; readdata = 32'h2402_0005; waitrequest = 1'b0; inst_req = 2'b11;
    tick();
    chk("fetch_read_c1", {31'h0, rd[0]}, 32'h1);
    chk("fetch_addr_c1", address[0], 32'hBFC0_0000);
    chk("fetch_be_c1", {28'h0, byteenable[0]}, 32'hF);
    tick();
    chk("fetch_ack_c2", {31'h0, inst_ack[0]}, 32'h1);
    chk("fetch_rdata_c2", inst_rdata[0], 32'h2402_0005);
    tick();
    chk("fetch_ack_c3", {31'h0, inst_ack[0]}, 32'h0);
    chk("fetch_rdata_hold", inst_rdata[0], 32'h2402_0005);

    // Store with three waitrequest cycles.
    data_we = 1'b1; data_addr = 32'h0000_1004; data_wdata = 32'hDEAD_BEEF; data_be = 4'b0011;
    readdata = 32'h1234_5678; waitrequest = 1'b1; data_req = 2'b11;
    wcnt = 0; acks = 0; rseen = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      wcnt += int'(wr[0]);
      acks += int'(data_ack[0]);
      rseen |= rd[0];
      waitrequest = (i >= 4) ? 1'b0 : 1'b1;
    end
    chk("store_write_cycles", wcnt, 32'd4);
    chk("store_ack_count", acks, 32'd1);
    chk("store_no_read", {31'h0, rseen}, 32'h0);
    chk("store_rdata_kept", data_rdata[0], 32'h0);

    // Repeated double requests: fixed data priority vs round-robin.
    data_we = 1'b0; data_addr = 32'h0000_2000; inst_addr = 32'h0040_0000; data_be = 4'b1111;
    readdata = 32'hCAFE_0001; waitrequest = 1'b0;
    for (int r = 0; r < 4; r++) begin
      inst_req = 2'b11; data_req = 2'b11;
      wait_acks($sformatf("tie_round%0d_done", r), wd);
      gr0[r] = wd[0];
      gr1[r] = wd[1];
    end
    chk("tie_data_first_order", {28'h0, gr0}, 32'hF);
    chk("tie_round_robin_order", {28'h0, gr1}, 32'hA);
    wait_acks("tie_drain", wd);
    chk("tie_drain_is_inst", {30'h0, wd}, 32'h0);

    // Requester holds req through its ack cycle.
    auto_drop = 1'b0;
    inst_addr = 32'h0040_0004; readdata = 32'h8C43_0010; inst_req = 2'b11;
    reads = 0; acks = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      reads += int'(rd[0]);
      acks  += int'(inst_ack[0]);
      if (i == 3) inst_req = 2'b00;
    end
    chk("hold_bus_cycles", reads, 32'd1);
    chk("hold_ack_count", acks, 32'd1);
    auto_drop = 1'b1;

    // Reset while a load is stalled.
    data_addr = 32'h0000_3000; waitrequest = 1'b1; data_req = 2'b11;
    tick();
    chk("pre_reset_read", {31'h0, rd[0]}, 32'h1);
    reset = 1'b1;
    #1;
    chk("reset_read_drop", {30'h0, rd}, 32'h0);
    data_req = 2'b00;
    tick();
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      acks += int'(inst_ack[0]) + int'(data_ack[0]) + int'(inst_ack[1]) + int'(data_ack[1]);
    end
    chk("reset_no_ack", acks, 32'd0);
    chk("reset_rdata_cleared", data_rdata[0], 32'h0);

    // First tie after reset: instance 0 serves data, instance 1 starts at inst.
    inst_addr = 32'hBFC0_0004; data_addr = 32'h0000_0040; readdata = 32'h3C1D_BFC0;
    waitrequest = 1'b0; inst_req = 2'b11; data_req = 2'b11;
    tick();
    tick();
    chk("post_reset_data_ack0", {31'h0, data_ack[0]}, 32'h1);
    chk("post_reset_inst_ack1", {31'h0, inst_ack[1]}, 32'h1);
    chk("post_reset_inst_rdata1", inst_rdata[1], 32'h3C1D_BFC0);
    wait_acks("post_reset_drain", wd);
    chk("post_reset_drain_kind", {30'h0, wd}, 32'h2);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
